// File: rtl/fill_pkg.sv
// Shared types and widths for the pill-filling order sequencer.
package fill_pkg;

  localparam int unsigned PILL_W   = 5;
  localparam int unsigned BOTTLE_W = 6;
  localparam int unsigned TOTAL_W  = 10;
  localparam int unsigned CHG_W    = 4;
  localparam int unsigned ORDER_W  = PILL_W + BOTTLE_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    FILL   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  typedef struct packed {
    logic [PILL_W-1:0]   pills;
    logic [BOTTLE_W-1:0] bottles;
  } order_t;

  // An order is executable only with 1..max pills and at least one bottle.
  function automatic logic order_ok(input order_t o, input logic [PILL_W-1:0] max_pills);
    return (o.pills != '0) && (o.pills <= max_pills) && (o.bottles != '0);
  endfunction

endpackage

// File: rtl/fill_sequencer_order_fifo.sv
// Synchronous order queue; power-of-two depth, no read bypass.
module order_fifo
  import fill_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ORDER_W-1:0] din,
  output logic [ORDER_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [ORDER_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fill_sequencer.sv
// Queued pill-filling controller: validates orders, paces pill_add on tick,
// runs a bottle-change phase per bottle and keeps a saturating grand total.
// Optional build macro FILL_PAUSE_EN adds a pause input that freezes
// FILL/CHANGE progress while asserted.
module fill_sequencer
  import fill_pkg::*;
#(
  parameter int unsigned MAX_PILLS    = 20,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CHANGE_TICKS = 2,
  parameter int unsigned TOTAL_MAX    = 999
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        tick,
`ifdef FILL_PAUSE_EN
  input  logic        pause,
`endif
  input  logic        order_valid,
  output logic        order_ready,
  input  logic [4:0]  order_pills,
  input  logic [5:0]  order_bottles,
  output logic        pill_add,
  output logic        bottle_change,
  output logic [4:0]  pill_count,
  output logic [5:0]  bottle_count,
  output logic [9:0]  total_pills,
  output logic        busy,
  output logic        order_done,
  output logic        err,
  output logic [1:0]  state_o
);

  localparam logic [PILL_W-1:0]  MAX_P   = PILL_W'(MAX_PILLS);
  localparam logic [CHG_W-1:0]   CHG_LD  = CHG_W'(CHANGE_TICKS);
  localparam logic [TOTAL_W-1:0] TOT_MAX = TOTAL_W'(TOTAL_MAX);

  state_t             state;
  order_t             active;
  order_t             head;
  logic [CHG_W-1:0]   change_cnt;
  logic [ORDER_W-1:0] fifo_din;
  logic [ORDER_W-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               run_tick;
  logic [PILL_W-1:0]  next_pill;
  logic [BOTTLE_W-1:0] next_bottle;

`ifdef FILL_PAUSE_EN
  assign run_tick = tick && !pause;
`else
  assign run_tick = tick;
`endif

  assign fifo_din    = {order_pills, order_bottles};
  assign head        = fifo_dout;
  assign fifo_push   = order_valid && !fifo_full;
  assign fifo_pop    = (state == IDLE) && !fifo_empty;
  assign order_ready = !fifo_full;
  assign next_pill   = pill_count + 1'b1;
  assign next_bottle = bottle_count + 1'b1;

  // pill_add must coincide with the tick it consumes, so it is decoded from
  // the registered state plus the live tick rather than registered itself.
  assign pill_add      = (state == FILL) && run_tick;
  assign bottle_change = (state == CHANGE);
  assign busy          = (state != IDLE);
  assign state_o       = state;

  order_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Order FSM with its counters and registered status pulses.
  always_ff @(posedge clock) begin
    if (rst) begin
      state        <= IDLE;
      active       <= '0;
      change_cnt   <= '0;
      pill_count   <= '0;
      bottle_count <= '0;
      total_pills  <= '0;
      order_done   <= 1'b0;
      err          <= 1'b0;
    end else begin
      order_done <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            active       <= head;
            pill_count   <= '0;
            bottle_count <= '0;
            state        <= CHECK;
          end
        end
        CHECK: begin
          if (!order_ok(active, MAX_P)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            state <= FILL;
          end
        end
        FILL: begin
          if (run_tick) begin
            pill_count <= next_pill;
            if (total_pills != TOT_MAX) total_pills <= total_pills + 1'b1;
            if (next_pill == active.pills) begin
              change_cnt <= CHG_LD;
              state      <= CHANGE;
            end
          end
        end
        CHANGE: begin
          if (run_tick) begin
            change_cnt <= change_cnt - 1'b1;
            if (change_cnt == CHG_W'(1)) begin
              bottle_count <= next_bottle;
              pill_count   <= '0;
              if (next_bottle == active.bottles) begin
                order_done <= 1'b1;
                state      <= IDLE;
              end else begin
                state <= FILL;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
